// File: rtl/seq_link_pkg.sv
// Shared constants and types for the serial x / 1011-sync link.
// Both the transmitter (seq_pattern_tx) and the receive-side detector import
// this package so that the preamble definition cannot drift between ends.
//   state_t           transmitter frame state {IDLE, SYNC, DATA, PAR}
//   SYNC_LEN_DEFAULT  preamble length in bits
//   SYNC_PAT_DEFAULT  preamble bit pattern, sent MSB-first
//   max_int()         elaboration-time helper for sizing counters
package seq_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;

  localparam int          SYNC_LEN_DEFAULT = 4;
  localparam logic [3:0]  SYNC_PAT_DEFAULT = 4'b1011;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_piso_shift.sv
// Parallel-in serial-out shifter used for both the preamble and the payload.
// The register shifts towards the MSB; msb always shows the bit that the next
// shift will release, so the owner reads msb and pulses shift in one cycle.
// Ports:
//   clk    in  1  clock, rising edge
//   rst    in  1  asynchronous, active-high reset (clears the register)
//   load   in  1  capture din (has priority over shift)
//   shift  in  1  shift left by one, zero fill
//   din    in  W  parallel load value
//   msb    out 1  current MSB of the register
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter for the x / 1011-sync link.
// A word accepted over valid/ready is sent as SYNC_PAT (MSB-first) followed by
// the payload (MSB-first), one bit per clk on x_out, with x_en marking frame
// bits. Building with the PARITY_EN macro defined appends one even-parity bit
// after the payload; the port list is the same in both builds.
// Ports:
//   clk         in  1       clock, rising edge
//   rst         in  1       asynchronous, active-high reset
//   tx_data     in  DATA_W  payload word, sampled on accept
//   tx_valid    in  1       payload present
//   tx_ready    out 1       block can accept (IDLE and not in reset)
//   x_out       out 1       serial bit stream (registered)
//   x_en        out 1       x_out carries a frame bit (registered)
//   busy        out 1       frame in flight
//   frame_done  out 1       pulse coincident with the last frame bit
module seq_pattern_tx
  import seq_link_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_LEN = SYNC_LEN_DEFAULT,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_PAT_DEFAULT,
  parameter logic              IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              x_out,
  output logic              x_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(max_int(SYNC_LEN, DATA_W) + 1);

  // The first preamble bit goes straight to x_out on accept, so the preamble
  // shifter only needs to hold the remaining bits.
  localparam logic [SYNC_LEN-1:0] SYNC_REST = SYNC_PAT << 1;

`ifdef PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  state_t           state, state_n;
  // Counts bits still to be sent in the current state after the one on x_out.
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             x_out_n, x_en_n, done_n;
  logic             sync_load, sync_shift, sync_msb;
  logic             data_load, data_shift, data_msb;
  logic             accept;

  assign tx_ready = !rst && (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  piso_shift #(.W(SYNC_LEN)) u_sync_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (sync_load),
    .shift (sync_shift),
    .din   (SYNC_REST),
    .msb   (sync_msb)
  );

  piso_shift #(.W(DATA_W)) u_data_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (data_load),
    .shift (data_shift),
    .din   (tx_data),
    .msb   (data_msb)
  );

`ifdef PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^tx_data;
    end
  end
`endif

  // Next-state and next-output logic. Outputs are computed for the bit that
  // will appear on x_out after the coming edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    x_out_n    = IDLE_BIT;
    x_en_n     = 1'b0;
    done_n     = 1'b0;
    sync_load  = 1'b0;
    sync_shift = 1'b0;
    data_load  = 1'b0;
    data_shift = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = SYNC;
          cnt_n     = CNT_W'(SYNC_LEN - 1);
          x_out_n   = SYNC_PAT[SYNC_LEN-1];
          x_en_n    = 1'b1;
          sync_load = 1'b1;
          data_load = 1'b1;
        end
      end

      SYNC: begin
        x_en_n = 1'b1;
        if (cnt != '0) begin
          x_out_n    = sync_msb;
          sync_shift = 1'b1;
          cnt_n      = cnt - CNT_W'(1);
        end else begin
          state_n    = DATA;
          cnt_n      = CNT_W'(DATA_W - 1);
          x_out_n    = data_msb;
          data_shift = 1'b1;
          done_n     = !HAS_PAR && (DATA_W == 1);
        end
      end

      DATA: begin
        if (cnt != '0) begin
          x_en_n     = 1'b1;
          x_out_n    = data_msb;
          data_shift = 1'b1;
          cnt_n      = cnt - CNT_W'(1);
          done_n     = !HAS_PAR && (cnt == CNT_W'(1));
        end else begin
`ifdef PARITY_EN
          state_n = PAR;
          cnt_n   = '0;
          x_en_n  = 1'b1;
          x_out_n = par_bit;
          done_n  = 1'b1;
`else
          state_n = IDLE;
          cnt_n   = '0;
`endif
        end
      end

      PAR: begin
        state_n = IDLE;
        cnt_n   = '0;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      x_out      <= IDLE_BIT;
      x_en       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      x_out      <= x_out_n;
      x_en       <= x_en_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx (DATA_W=8, SYNC_LEN=4, SYNC_PAT=1011).
// Expected serial bits come from a frame model: preamble bits, payload bits
// MSB-first, then even parity when PARITY_EN is defined.
module tb_seq_pattern_tx;

`ifdef PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int SL = 4;
  localparam int DW = 8;
  localparam int F  = SL + DW + PB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       x_out;
  logic       x_en;
  logic       busy;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  seq_pattern_tx #(
    .DATA_W   (DW),
    .SYNC_LEN (SL),
    .SYNC_PAT (4'b1011),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .x_out      (x_out),
    .x_en       (x_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Frame model: bit i of the frame on the wire.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    logic [3:0] sp;
    logic [3:0] st;
    logic [7:0] dt;
    sp = 4'b1011;
    if (i < SL) begin
      st = sp >> (SL - 1 - i);
      return st[0];
    end else if (i < SL + DW) begin
      dt = d >> (DW - 1 - (i - SL));
      return dt[0];
    end
    return ^d;
  endfunction

  task automatic idle_checks(input string tag);
    check({tag, "_x_out"}, x_out, 1'b0);
    check({tag, "_x_en"}, x_en, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, frame_done, 1'b0);
  endtask

  // Caller has set tx_data/tx_valid so the next edge accepts d.
  // hold: keep tx_valid high throughout; noise: scramble inputs while busy.
  task automatic send_frame(input logic [7:0] d, input bit hold, input bit noise);
    for (int i = 0; i < F; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bit%0d_x_out", i), x_out, exp_bit(d, i));
      check($sformatf("bit%0d_x_en", i), x_en, 1'b1);
      check($sformatf("bit%0d_done", i), frame_done, (i == F - 1));
      check($sformatf("bit%0d_ready", i), tx_ready, 1'b0);
      check($sformatf("bit%0d_busy", i), busy, 1'b1);
      if (noise && i < F - 1) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = hold;
      end
    end
    @(posedge clk);
    #1;
    idle_checks("gap");
    check("gap_ready", tx_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    idle_checks("rst");
    check("rst_ready", tx_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_ready", tx_ready, 1'b1);
    // Reset asserted while idle.
    rst = 1'b1;
    #1;
    idle_checks("rst_idle");
    check("rst_idle_ready", tx_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel2_ready", tx_ready, 1'b1);

    // Single frame 0xA5.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0);

    // Held valid: 0x00 then 0xFF separated by exactly one idle cycle.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0);
    tx_data = 8'hFF;
    send_frame(8'hFF, 1'b0, 1'b0);

    // Inputs scrambled while busy must not disturb the frame in flight.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1);

    // Parity case word.
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    send_frame(8'h07, 1'b0, 1'b0);

    // Reset during payload bit 3: outputs drop at once, next frame is whole.
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    repeat (SL + 4) begin
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
    end
    check("pre_abort_x_en", x_en, 1'b1);
    rst = 1'b1;
    #1;
    idle_checks("abort");
    check("abort_ready", tx_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle_checks("post_abort");
    check("post_abort_ready", tx_ready, 1'b1);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);

    // Randomized frames, some with noise, some held back-to-back.
    for (int k = 0; k < 8; k++) begin
      d        = 8'($urandom);
      tx_data  = d;
      tx_valid = 1'b1;
      send_frame(d, (k % 3) == 1, (k % 2) == 0);
      if ((k % 3) != 1) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
          idle_checks("rand_idle");
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
